// File: rtl/neur_seq_ctrl.sv
// rtl/neur_seq_ctrl.sv - neural-unit job sequencer; NEUR_SEQ_PERF_EN builds the stall/job counters
module neur_seq_ctrl #(
    parameter int LEN_W     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clk_i_fast,
    input  logic             rstn_i,
    input  logic             step_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic [31:0]      cfg_bias_i,
    input  logic [31:0]      cfg_shift_mode_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic [31:0]      data_w_i,
    input  logic [31:0]      data_x_i,
    output logic             nu_bias_in_o,
    output logic             nu_valid_in_o,
    output logic             nu_get_res_o,
    output logic [31:0]      nu_bias_shift_mode_o,
    output logic [31:0]      nu_weights_o,
    output logic [31:0]      nu_input_val_o,
    input  logic             nu_valid_out_i,
    input  logic [31:0]      nu_output_val_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_data_o,
    output logic             busy_o,
    output logic [31:0]      perf_stall_o,
    output logic [15:0]      perf_jobs_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BIAS   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    localparam int               DRN_W    = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC);

    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_remaining;
    logic [DRN_W-1:0] r_drain;
    logic [31:0]      r_bias;
    logic [31:0]      r_shift;
    logic             r_nu_bias_in;
    logic             r_nu_valid_in;
    logic             r_nu_get_res;
    logic [31:0]      r_nu_shift;
    logic [31:0]      r_nu_weights;
    logic [31:0]      r_nu_input;
    logic [31:0]      r_res_data;

    logic w_data_ready;
    logic w_data_fire;
    logic w_last_word;

    assign w_data_ready = (r_state == S_STREAM) && step_i && (r_remaining != '0);
    assign w_data_fire  = w_data_ready && data_valid_i;
    assign w_last_word  = (r_remaining == LEN_W'(1));

    assign cfg_ready_o          = (r_state == S_IDLE);
    assign data_ready_o         = w_data_ready;
    assign busy_o               = (r_state != S_IDLE);
    assign res_valid_o          = (r_state == S_HOLD);
    assign res_data_o           = r_res_data;
    assign nu_bias_in_o         = r_nu_bias_in;
    assign nu_valid_in_o        = r_nu_valid_in;
    assign nu_get_res_o         = r_nu_get_res;
    assign nu_bias_shift_mode_o = r_nu_shift;
    assign nu_weights_o         = r_nu_weights;
    assign nu_input_val_o       = r_nu_input;

    // Every nu_* register moves only on a step edge, so the slow unit sees each command for one full period.
    always_ff @(posedge clk_i_fast or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_drain       <= '0;
            r_bias        <= '0;
            r_shift       <= '0;
            r_nu_bias_in  <= 1'b0;
            r_nu_valid_in <= 1'b0;
            r_nu_get_res  <= 1'b0;
            r_nu_shift    <= '0;
            r_nu_weights  <= '0;
            r_nu_input    <= '0;
            r_res_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid_i) begin
                        r_remaining <= cfg_len_i;
                        r_bias      <= cfg_bias_i;
                        r_shift     <= cfg_shift_mode_i;
                        r_state     <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    if (step_i) begin
                        r_nu_bias_in <= 1'b1;
                        r_nu_weights <= r_bias;
                        r_nu_shift   <= r_shift;
                        if (r_remaining == '0) begin
                            r_state <= S_DRAIN;
                            r_drain <= DRN_LOAD;
                        end else begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (step_i) begin
                        r_nu_bias_in  <= 1'b0;
                        r_nu_valid_in <= w_data_fire;
                        if (w_data_fire) begin
                            r_nu_weights <= data_w_i;
                            r_nu_input   <= data_x_i;
                            r_remaining  <= r_remaining - LEN_W'(1);
                            if (w_last_word) begin
                                r_state <= S_DRAIN;
                                r_drain <= DRN_LOAD;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (step_i) begin
                        r_nu_bias_in  <= 1'b0;
                        r_nu_valid_in <= 1'b0;
                        if (r_drain <= DRN_W'(1)) begin
                            r_state <= S_READ;
                            r_drain <= '0;
                        end else begin
                            r_drain <= r_drain - DRN_W'(1);
                        end
                    end
                end
                S_READ: begin
                    // A result only counts once the unit has seen get_res for at least one period.
                    if (step_i) begin
                        if (nu_valid_out_i && r_nu_get_res) begin
                            r_res_data   <= nu_output_val_i;
                            r_nu_get_res <= 1'b0;
                            r_state      <= S_HOLD;
                        end else begin
                            r_nu_get_res <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (res_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef NEUR_SEQ_PERF_EN
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_jobs;
    logic        w_stall_evt;
    logic        w_job_evt;

    assign w_stall_evt = (r_state == S_STREAM) && step_i && !w_data_fire;
    assign w_job_evt   = (r_state == S_HOLD) && res_ready_i;

    always_ff @(posedge clk_i_fast or negedge rstn_i) begin
        if (!rstn_i) begin
            r_perf_stall <= '0;
            r_perf_jobs  <= '0;
        end else begin
            if (w_stall_evt && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_job_evt && (r_perf_jobs != '1)) begin
                r_perf_jobs <= r_perf_jobs + 16'd1;
            end
        end
    end

    assign perf_stall_o = r_perf_stall;
    assign perf_jobs_o  = r_perf_jobs;
`else
    assign perf_stall_o = '0;
    assign perf_jobs_o  = '0;
`endif

endmodule

// File: tb/tb_neur_seq_ctrl.sv
// tb/tb_neur_seq_ctrl.sv - scoreboard bench for neur_seq_ctrl with a behavioural neural-unit model
module tb_neur_seq_ctrl;

    localparam int LEN_W     = 4;
    localparam int DRAIN_CYC = 4;
`ifdef NEUR_SEQ_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic             clk_i_fast = 1'b0;
    logic             rstn_i;
    logic             step_i;
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [LEN_W-1:0] cfg_len_i;
    logic [31:0]      cfg_bias_i;
    logic [31:0]      cfg_shift_mode_i;
    logic             data_valid_i;
    logic             data_ready_o;
    logic [31:0]      data_w_i;
    logic [31:0]      data_x_i;
    logic             nu_bias_in_o;
    logic             nu_valid_in_o;
    logic             nu_get_res_o;
    logic [31:0]      nu_bias_shift_mode_o;
    logic [31:0]      nu_weights_o;
    logic [31:0]      nu_input_val_o;
    logic             nu_valid_out_i;
    logic [31:0]      nu_output_val_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [31:0]      res_data_o;
    logic             busy_o;
    logic [31:0]      perf_stall_o;
    logic [15:0]      perf_jobs_o;

    always #5 clk_i_fast = ~clk_i_fast;

    neur_seq_ctrl #(.LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk_i_fast(clk_i_fast), .rstn_i(rstn_i), .step_i(step_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_len_i(cfg_len_i),
        .cfg_bias_i(cfg_bias_i), .cfg_shift_mode_i(cfg_shift_mode_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
        .data_w_i(data_w_i), .data_x_i(data_x_i),
        .nu_bias_in_o(nu_bias_in_o), .nu_valid_in_o(nu_valid_in_o), .nu_get_res_o(nu_get_res_o),
        .nu_bias_shift_mode_o(nu_bias_shift_mode_o), .nu_weights_o(nu_weights_o),
        .nu_input_val_o(nu_input_val_o), .nu_valid_out_i(nu_valid_out_i),
        .nu_output_val_i(nu_output_val_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .busy_o(busy_o), .perf_stall_o(perf_stall_o),
        .perf_jobs_o(perf_jobs_o)
    );

    typedef struct {
        int          len;
        int          dly;
        int          rdy;
        int          stall_at;
        int          stall_n;
        logic [31:0] exp;
    } job_t;

    job_t        job_q[$];
    logic [31:0] qw[$];
    logic [31:0] qx[$];

    int checks = 0;
    int errors = 0;
    int results_done = 0;
    int accepted_jobs = 0;
    int phase = 0;
    int acc_cnt = 0;
    int stall_run = 0;
    int exp_stall = 0;
    int exp_jobs = 0;
    int hold_cnt = 0;
    bit pend_acc = 0;
    bit streaming = 0;
    bit snap_ok = 0;
    logic [98:0] snap;
    logic [31:0] held;
    logic [31:0] nu_acc = 0;
    int nu_bias_cnt = 0;
    int nu_vin_cnt = 0;
    int nu_zero = 0;
    int nu_gr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic abort(input string name);
        errors++;
        $display("FAIL %s: got timeout expected progress", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [98:0] nu_bundle();
        return {nu_bias_in_o, nu_valid_in_o, nu_get_res_o,
                nu_bias_shift_mode_o, nu_weights_o, nu_input_val_o};
    endfunction

    // Slow neural unit: consumes the command held during the last step period.
    task automatic nu_observe();
        nu_valid_out_i  = 1'b0;
        nu_output_val_i = $urandom;
        check("nu_strobe_exclusive",
              32'($countones({nu_bias_in_o, nu_valid_in_o, nu_get_res_o}) <= 1), 1);
        if (nu_bias_in_o) begin
            nu_acc      = nu_weights_o << nu_bias_shift_mode_o[4:0];
            nu_bias_cnt = nu_bias_cnt + 1;
            nu_vin_cnt  = 0;
            nu_zero     = 0;
            nu_gr_cnt   = 0;
            acc_cnt     = 0;
            stall_run   = 0;
            streaming   = (job_q.size() > 0) && (job_q[0].len > 0);
        end else if (nu_valid_in_o) begin
            nu_acc     = nu_acc + nu_weights_o * nu_input_val_o;
            nu_vin_cnt = nu_vin_cnt + 1;
            nu_zero    = 0;
        end else if (nu_get_res_o) begin
            nu_gr_cnt = nu_gr_cnt + 1;
            if (job_q.size() == 0) begin
                check("get_res_without_job", nu_get_res_o, 0);
            end else begin
                if (nu_gr_cnt == 1) begin
                    check("bias_periods", nu_bias_cnt, 1);
                    check("valid_in_periods", nu_vin_cnt, job_q[0].len);
                    check("drain_periods", nu_zero, DRAIN_CYC);
                end
                if (nu_gr_cnt > job_q[0].dly + 1) begin
                    check("get_res_periods", nu_gr_cnt, job_q[0].dly + 1);
                end
                if (nu_gr_cnt == job_q[0].dly + 1) begin
                    nu_valid_out_i  = 1'b1;
                    nu_output_val_i = nu_acc;
                    nu_bias_cnt     = 0;
                end
            end
        end else begin
            nu_zero = nu_zero + 1;
        end
        if (!nu_get_res_o && ($urandom_range(0, 3) == 0)) begin
            nu_valid_out_i = 1'b1;
        end
    endtask

    initial begin : env
        step_i = 1'b0; data_valid_i = 1'b0; data_w_i = '0; data_x_i = '0;
        nu_valid_out_i = 1'b0; nu_output_val_i = '0;
        forever begin
            @(negedge clk_i_fast);
            if (pend_acc) begin
                if (qw.size() > 0) begin
                    void'(qw.pop_front());
                    void'(qx.pop_front());
                end
                pend_acc = 0;
            end
            phase  = (phase == 3) ? 0 : phase + 1;
            step_i = (phase == 0);
            if (rstn_i) begin
                if (phase == 1) begin
                    snap    = nu_bundle();
                    snap_ok = 1;
                end else if (snap_ok) begin
                    check("nu_hold_between_steps", 32'(nu_bundle() === snap), 1);
                end
                if (step_i) nu_observe();
            end
            if (step_i) begin
                if (streaming && qw.size() > 0) begin
                    if (job_q[0].stall_at >= 0 && acc_cnt == job_q[0].stall_at &&
                        stall_run < job_q[0].stall_n) begin
                        data_valid_i = 1'b0;
                        stall_run    = stall_run + 1;
                    end else if (job_q[0].stall_at == -2) begin
                        data_valid_i = ($urandom_range(0, 2) != 0);
                    end else begin
                        data_valid_i = 1'b1;
                    end
                    data_w_i = qw[0];
                    data_x_i = qx[0];
                end else begin
                    data_valid_i = 1'($urandom_range(0, 1));
                    data_w_i     = $urandom;
                    data_x_i     = $urandom;
                end
            end
            #1;
            if (rstn_i) begin
                if (step_i) begin
                    check("data_ready_in_stream", data_ready_o, streaming);
                    if (data_valid_i && data_ready_o && streaming) begin
                        acc_cnt  = acc_cnt + 1;
                        pend_acc = 1;
                        if (acc_cnt >= job_q[0].len) streaming = 0;
                    end else if (streaming) begin
                        exp_stall = exp_stall + 1;
                    end
                end else begin
                    check("data_ready_offstep", data_ready_o, 0);
                end
            end
        end
    end

    initial begin : monitor
        res_ready_i = 1'b0;
        forever begin
            @(negedge clk_i_fast);
            if (!rstn_i) begin
                res_ready_i = 1'b0;
                hold_cnt    = 0;
            end else if (res_ready_i) begin
                res_ready_i = 1'b0;
                check("res_valid_after_handshake", res_valid_o, 0);
            end else if (res_valid_o) begin
                if (job_q.size() == 0) begin
                    check("res_valid_without_job", res_valid_o, 0);
                    res_ready_i = 1'b1;
                end else begin
                    if (hold_cnt == 0) held = res_data_o;
                    else check("res_data_stable", res_data_o, held);
                    check("cfg_ready_in_hold", cfg_ready_o, 0);
                    check("busy_in_hold", busy_o, 1);
                    if (hold_cnt >= job_q[0].rdy) begin
                        check("res_data", res_data_o, job_q[0].exp);
                        check("perf_stall", perf_stall_o, PERF_ON ? 32'(exp_stall) : 32'd0);
                        check("perf_jobs", 32'(perf_jobs_o), PERF_ON ? 32'(exp_jobs) : 32'd0);
                        void'(job_q.pop_front());
                        results_done = results_done + 1;
                        exp_jobs     = exp_jobs + 1;
                        hold_cnt     = 0;
                        res_ready_i  = 1'b1;
                    end else begin
                        hold_cnt = hold_cnt + 1;
                    end
                end
            end
        end
    end

    task automatic issue_job(input int len, input int dly, input int rdy,
                             input int st_at, input int st_n);
        job_t        j;
        logic [31:0] b, sh, w, x;
        bit          got;
        b = $urandom;
        sh = $urandom;
        j.exp = b << sh[4:0];
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            x = $urandom;
            j.exp = j.exp + w * x;
            qw.push_back(w);
            qx.push_back(x);
        end
        j.len = len; j.dly = dly; j.rdy = rdy; j.stall_at = st_at; j.stall_n = st_n;
        job_q.push_back(j);
        @(negedge clk_i_fast);
        cfg_len_i = LEN_W'(len);
        cfg_bias_i = b;
        cfg_shift_mode_i = sh;
        cfg_valid_i = 1'b1;
        got = 0;
        for (int c = 0; c < 4000; c++) begin
            if (cfg_ready_o) begin
                got = 1;
                break;
            end
            @(negedge clk_i_fast);
        end
        if (!got) abort("cfg_accept");
        check("no_overlap", results_done, accepted_jobs);
        @(posedge clk_i_fast);
        #1;
        cfg_valid_i = 1'b0;
        cfg_len_i = LEN_W'($urandom);
        cfg_bias_i = $urandom;
        cfg_shift_mode_i = $urandom;
        accepted_jobs = accepted_jobs + 1;
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i_fast);
            if (results_done == accepted_jobs && !res_ready_i) begin
                got = 1;
                break;
            end
        end
        if (!got) abort("result_drain");
    endtask

    initial begin : main
        rstn_i = 1'b0;
        cfg_valid_i = 1'b0; cfg_len_i = '0; cfg_bias_i = '0; cfg_shift_mode_i = '0;
        repeat (3) @(posedge clk_i_fast);
        #2;
        check("rst_cfg_ready", cfg_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_res_data", res_data_o, 0);
        check("rst_nu_cmd", 32'(nu_bundle() != 0), 0);
        check("rst_perf", perf_stall_o | 32'(perf_jobs_o), 0);
        rstn_i = 1'b1;

        issue_job(3, 0, 0, -1, 0);
        issue_job(4, 0, 1, 2, 2);
        issue_job(0, 1, 0, -1, 0);
        issue_job(2, 3, 0, -1, 0);
        issue_job(15, 0, 0, -2, 0);
        issue_job(3, 0, 10, -1, 0);
        issue_job(2, 0, 0, -1, 0);
        wait_idle();

        issue_job(5, 0, 0, -1, 0);
        begin
            bit got = 0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk_i_fast);
                #2;
                if (acc_cnt >= 2) begin
                    got = 1;
                    break;
                end
            end
            if (!got) abort("reset_job_words");
        end
        @(posedge clk_i_fast);
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_nu_cmd", 32'(nu_bundle() != 0), 0);
        check("arst_res_valid", res_valid_o, 0);
        check("arst_res_data", res_data_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_perf", perf_stall_o | 32'(perf_jobs_o), 0);
        job_q.delete(); qw.delete(); qx.delete();
        pend_acc = 0; streaming = 0; snap_ok = 0; acc_cnt = 0;
        exp_stall = 0; exp_jobs = 0;
        nu_bias_cnt = 0; nu_vin_cnt = 0; nu_zero = 0; nu_gr_cnt = 0;
        nu_valid_out_i = 1'b0;
        accepted_jobs = results_done;
        repeat (2) @(posedge clk_i_fast);
        #2;
        rstn_i = 1'b1;
        #1;
        check("post_rst_cfg_ready", cfg_ready_o, 1);
        check("post_rst_busy", busy_o, 0);

        issue_job(3, 0, 0, -1, 0);
        for (int k = 0; k < 10; k++) begin
            issue_job($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 1) == 0) ? -2 : -1, 0);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neur_seq_ctrl.md
NEUR_SEQ_CTRL -- requirements
Module: neur_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the job word-count field.
REQ-002 SHALL have parameter DRAIN_CYC, default 4: step cycles waited after the last data word before readout.
REQ-003 SHALL have port clk_i_fast, input, 1: clock for all state.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port step_i, input, 1: one-fast-cycle strobe aligned to each slow-clock (clk_i) edge of the neural unit.
REQ-006 SHALL have ports cfg_valid_i (in, 1), cfg_ready_o (out, 1), cfg_len_i (in, LEN_W), cfg_bias_i (in, 32) and cfg_shift_mode_i (in, 32): job descriptor handshake.
REQ-007 SHALL have ports data_valid_i (in, 1), data_ready_o (out, 1), data_w_i (in, 32) and data_x_i (in, 32): packed weight/activation word stream.
REQ-008 SHALL have ports nu_bias_in_o, nu_valid_in_o and nu_get_res_o (out, 1 each), plus nu_bias_shift_mode_o, nu_weights_o and nu_input_val_o (out, 32 each): neural unit command.
REQ-009 SHALL have ports nu_valid_out_i (in, 1) and nu_output_val_i (in, 32): neural unit result.
REQ-010 SHALL have ports res_valid_o (out, 1), res_ready_i (in, 1), res_data_o (out, 32) and busy_o (out, 1).
REQ-011 SHALL have ports perf_stall_o (out, 32) and perf_jobs_o (out, 16).

Function
REQ-012 SHALL implement states IDLE, BIAS, STREAM, DRAIN, READ and HOLD; busy_o = (state != IDLE).
REQ-013 SHALL update all nu_* outputs only on fast edges where step_i=1, so every command is held for exactly one slow period.
REQ-014 cfg_ready_o = (state==IDLE); a job is accepted on cfg_valid_i & cfg_ready_o, latching len, bias and shift_mode, then IDLE->BIAS.
REQ-015 In BIAS, on the first step_i: nu_bias_in_o=1, nu_weights_o=bias, nu_bias_shift_mode_o=shift_mode; state->STREAM, or ->DRAIN if len==0.
REQ-016 data_ready_o = (state==STREAM) & step_i & (remaining != 0), combinational.
REQ-017 In STREAM, each step with an accepted word: nu_valid_in_o=1, nu_weights_o=data_w_i, nu_input_val_o=data_x_i, remaining decremented.
REQ-018 In STREAM, a step with no accepted word: nu_valid_in_o=0 (bubble), data registers held, remaining unchanged.
REQ-019 The step that accepts the final word SHALL move the state to DRAIN; the DRAIN counter loads DRAIN_CYC.
REQ-020 In DRAIN, all nu strobes are 0; after DRAIN_CYC step cycles the state moves to READ.
REQ-021 In READ, nu_get_res_o=1 from the first step onward.
REQ-022 In READ, a step where nu_valid_out_i=1 and nu_get_res_o is already 1 SHALL capture nu_output_val_i into res_data_o, drop nu_get_res_o and move to HOLD.
REQ-023 In HOLD, res_valid_o=1 with res_data_o stable until res_ready_i=1 (fast-clock handshake), then IDLE.
REQ-024 A new job SHALL be accepted only in IDLE: no overlap, and cfg_valid_i is ignored in all other states.
REQ-025 The remaining counter SHALL NOT wrap below 0; len of all-ones SHALL stream 2^LEN_W-1 words.
REQ-026 step_i=0 SHALL freeze the state machine in BIAS, STREAM, DRAIN and READ; HOLD and IDLE handshakes ignore step_i.

Reset
REQ-027 On rstn_i low, asynchronously: state=IDLE; all nu_* outputs, res_valid_o, res_data_o, counters and perf outputs = 0.
REQ-028 Reset mid-job SHALL discard the job with no result produced; cfg_ready_o=1 on the first cycle after release.

Configuration
REQ-029 With NEUR_SEQ_PERF_EN defined: perf_stall_o counts STREAM step cycles with no accepted word, and perf_jobs_o counts HOLD->IDLE handshakes; both saturate.
REQ-030 Without NEUR_SEQ_PERF_EN: perf_stall_o and perf_jobs_o are tied to 0 and no counter logic is built.

Verification
REQ-031 Job len=3, data always valid, step every 4 fast cycles -> exactly 1 bias_in and 3 valid_in slow periods, DRAIN of 4 steps, then get_res, then res_data_o equal to the model output, held until res_ready_i.
REQ-032 Job len=4, data_valid_i low for 2 steps mid-stream -> 2 bubbles with nu_valid_in_o=0; perf_stall_o=2 with NEUR_SEQ_PERF_EN defined, 0 without.
REQ-033 Job len=0 -> BIAS goes directly to DRAIN; the result equals the shifted bias only; data_ready_o never asserted.
REQ-034 nu_valid_out_i delayed 3 steps in READ -> nu_get_res_o held for 4 slow periods; a single result is captured.
REQ-035 rstn_i pulsed low during STREAM after 2 of 5 words -> all outputs 0 immediately, no res_valid_o, and the next job runs normally.
REQ-036 res_ready_i held low for 10 cycles in HOLD -> res_data_o stable, cfg_ready_o=0 and a pending cfg_valid_i is not accepted until the handshake completes.
